// File: rtl/img_proc_pkg.sv
// Shared definitions for the binary-image bounding-box stage: FSM states,
// overlay colours and coordinate width.
package img_proc_pkg;

    localparam int COORD_W = 10;
    localparam int COUNT_W = 20;

    localparam logic [23:0] COLOR_WHITE = 24'hFFFFFF;
    localparam logic [23:0] COLOR_BLACK = 24'h000000;
    localparam logic [23:0] COLOR_RED   = 24'hFF0000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_LATCH    = 2'd3
    } locator_state_t;

endpackage

// File: rtl/bit_box_locator_frame_pos_counter.sv
// Pixel position tracking for a vsync/href/clken stream, with edge detection
// and an out-of-display flag for pixels past the saturated coordinates.
module frame_pos_counter
    import img_proc_pkg::*;
#(
    parameter logic [COORD_W-1:0] IMG_HDISP = 10'd800,
    parameter logic [COORD_W-1:0] IMG_VDISP = 10'd600
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vsync,
    input  logic               href,
    input  logic               clken,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               in_range,
    output logic               vsync_rise,
    output logic               vsync_fall
);

    logic vsync_d;
    logic href_d;
    logic href_fall;
    logic x_over;
    logic y_over;

    assign vsync_rise = vsync & ~vsync_d;
    assign vsync_fall = ~vsync & vsync_d;
    assign href_fall  = ~href & href_d;
    assign in_range   = ~x_over & ~y_over;

    // Once the last column/line has been consumed the over flag marks any
    // further pixels as outside the display instead of wrapping the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
            x       <= '0;
            y       <= '0;
            x_over  <= 1'b0;
            y_over  <= 1'b0;
        end else begin
            vsync_d <= vsync;
            href_d  <= href;

            if (!href) begin
                x      <= '0;
                x_over <= 1'b0;
            end else if (vsync && clken && !x_over) begin
                if (x == IMG_HDISP - 10'd1) begin
                    x_over <= 1'b1;
                end else begin
                    x <= x + 10'd1;
                end
            end

            if (vsync_rise) begin
                y      <= '0;
                y_over <= 1'b0;
            end else if (vsync && href_fall && !y_over) begin
                if (y == IMG_VDISP - 10'd1) begin
                    y_over <= 1'b1;
                end else begin
                    y <= y + 10'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bit_box_locator.sv
// Bounding box of white pixels per frame, latched at end of frame and drawn
// as a red rectangle over the following frame's binary image.
module bit_box_locator
    import img_proc_pkg::*;
#(
    parameter logic [COORD_W-1:0] IMG_HDISP  = 10'd800,
    parameter logic [COORD_W-1:0] IMG_VDISP  = 10'd600,
    parameter logic [COUNT_W-1:0] MIN_PIXELS = 20'd64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               per_frame_vsync,
    input  logic               per_frame_href,
    input  logic               per_frame_clken,
    input  logic               per_img_Bit,
    output logic               post_frame_vsync,
    output logic               post_frame_href,
    output logic               post_frame_clken,
    output logic [23:0]        post_img,
    output logic [COORD_W-1:0] box_xmin,
    output logic [COORD_W-1:0] box_xmax,
    output logic [COORD_W-1:0] box_ymin,
    output logic [COORD_W-1:0] box_ymax,
    output logic [COUNT_W-1:0] box_pixels,
    output logic               box_found,
    output logic               box_valid
);

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               in_range;
    logic               vsync_rise;
    logic               vsync_fall;
    logic               white_pixel;
    logic               on_border;

    locator_state_t     state;
    logic [COORD_W-1:0] acc_xmin;
    logic [COORD_W-1:0] acc_xmax;
    logic [COORD_W-1:0] acc_ymin;
    logic [COORD_W-1:0] acc_ymax;
    logic [COUNT_W-1:0] acc_count;

    frame_pos_counter #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .vsync      (per_frame_vsync),
        .href       (per_frame_href),
        .clken      (per_frame_clken),
        .x          (x),
        .y          (y),
        .in_range   (in_range),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall)
    );

    assign white_pixel = per_frame_vsync & per_frame_href & per_frame_clken
                       & in_range & per_img_Bit;

    assign on_border = (((x == box_xmin) || (x == box_xmax)) &&
                        (y >= box_ymin) && (y <= box_ymax)) ||
                       (((y == box_ymin) || (y == box_ymax)) &&
                        (x >= box_xmin) && (x <= box_xmax));

    // Results are loaded on the edge that enters LATCH so that box_valid and
    // the new box_* values appear together for exactly that one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            acc_xmin   <= '0;
            acc_xmax   <= '0;
            acc_ymin   <= '0;
            acc_ymax   <= '0;
            acc_count  <= '0;
            box_xmin   <= '0;
            box_xmax   <= '0;
            box_ymin   <= '0;
            box_ymax   <= '0;
            box_pixels <= '0;
            box_found  <= 1'b0;
            box_valid  <= 1'b0;
        end else begin
            box_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!per_frame_vsync) begin
                        state <= ST_WAIT_SOF;
                    end
                end
                ST_WAIT_SOF: begin
                    if (vsync_rise) begin
                        state     <= ST_ACTIVE;
                        acc_xmin  <= IMG_HDISP - 10'd1;
                        acc_ymin  <= IMG_VDISP - 10'd1;
                        acc_xmax  <= '0;
                        acc_ymax  <= '0;
                        acc_count <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (vsync_fall) begin
                        state      <= ST_LATCH;
                        box_valid  <= 1'b1;
                        box_pixels <= acc_count;
                        if (acc_count >= MIN_PIXELS) begin
                            box_xmin  <= acc_xmin;
                            box_xmax  <= acc_xmax;
                            box_ymin  <= acc_ymin;
                            box_ymax  <= acc_ymax;
                            box_found <= 1'b1;
                        end else begin
                            box_xmin  <= '0;
                            box_xmax  <= '0;
                            box_ymin  <= '0;
                            box_ymax  <= '0;
                            box_found <= 1'b0;
                        end
                    end else if (white_pixel) begin
                        if (x < acc_xmin) acc_xmin <= x;
                        if (x > acc_xmax) acc_xmax <= x;
                        if (y < acc_ymin) acc_ymin <= y;
                        if (y > acc_ymax) acc_ymax <= y;
                        if (acc_count != 20'hFFFFF) acc_count <= acc_count + 20'd1;
                    end
                end
                ST_LATCH: begin
                    state <= ST_WAIT_SOF;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Overlay uses the box latched from the previous frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img         <= COLOR_BLACK;
        end else begin
            post_frame_vsync <= per_frame_vsync;
            post_frame_href  <= per_frame_href;
            post_frame_clken <= per_frame_clken;
            if (!per_frame_href) begin
                post_img <= COLOR_BLACK;
            end else if (box_found && on_border) begin
                post_img <= COLOR_RED;
            end else if (per_img_Bit) begin
                post_img <= COLOR_WHITE;
            end else begin
                post_img <= COLOR_BLACK;
            end
        end
    end

endmodule

// File: tb/tb_bit_box_locator.sv
// Directed frames on a 16x8 image driven into two locator instances
// (MIN_PIXELS 1 and 4), with box results and overlay pixels scoreboarded.
module tb_bit_box_locator;

    localparam int HD = 16;
    localparam int VD = 8;

    typedef struct {
        logic [9:0]  xmin;
        logic [9:0]  xmax;
        logic [9:0]  ymin;
        logic [9:0]  ymax;
        logic [19:0] pix;
        logic        found;
    } res_t;

    typedef struct {
        logic [23:0] img;
        logic        v;
        logic        h;
        logic        c;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vsync = 1'b0;
    logic href = 1'b0;
    logic clken = 1'b0;
    logic bit_in = 1'b0;

    logic        a_pv, a_ph, a_pc, a_found, a_valid;
    logic [23:0] a_img;
    logic [9:0]  a_xmin, a_xmax, a_ymin, a_ymax;
    logic [19:0] a_pix;

    logic        b_pv, b_ph, b_pc, b_found, b_valid;
    logic [23:0] b_img;
    logic [9:0]  b_xmin, b_xmax, b_ymin, b_ymax;
    logic [19:0] b_pix;

    int n_assert = 0;
    int n_fail   = 0;

    res_t q1[$];
    res_t q4[$];
    pix_t qpix[$];
    res_t eb;
    bit   valid_due = 1'b0;
    bit   img [0:VD-1][0:HD-1];

    always #5 clk = ~clk;

    bit_box_locator #(
        .IMG_HDISP (10'd16),
        .IMG_VDISP (10'd8),
        .MIN_PIXELS(20'd1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .per_frame_vsync (vsync),
        .per_frame_href  (href),
        .per_frame_clken (clken),
        .per_img_Bit     (bit_in),
        .post_frame_vsync(a_pv),
        .post_frame_href (a_ph),
        .post_frame_clken(a_pc),
        .post_img        (a_img),
        .box_xmin        (a_xmin),
        .box_xmax        (a_xmax),
        .box_ymin        (a_ymin),
        .box_ymax        (a_ymax),
        .box_pixels      (a_pix),
        .box_found       (a_found),
        .box_valid       (a_valid)
    );

    bit_box_locator #(
        .IMG_HDISP (10'd16),
        .IMG_VDISP (10'd8),
        .MIN_PIXELS(20'd4)
    ) dut4 (
        .clk             (clk),
        .rst             (rst),
        .per_frame_vsync (vsync),
        .per_frame_href  (href),
        .per_frame_clken (clken),
        .per_img_Bit     (bit_in),
        .post_frame_vsync(b_pv),
        .post_frame_href (b_ph),
        .post_frame_clken(b_pc),
        .post_img        (b_img),
        .box_xmin        (b_xmin),
        .box_xmax        (b_xmax),
        .box_ymin        (b_ymin),
        .box_ymax        (b_ymax),
        .box_pixels      (b_pix),
        .box_found       (b_found),
        .box_valid       (b_valid)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic res_t calc(input int minp);
        res_t r;
        int cnt = 0;
        int xmn = HD - 1;
        int xmx = 0;
        int ymn = VD - 1;
        int ymx = 0;
        for (int yy = 0; yy < VD; yy++) begin
            for (int xx = 0; xx < HD; xx++) begin
                if (img[yy][xx]) begin
                    cnt++;
                    if (xx < xmn) xmn = xx;
                    if (xx > xmx) xmx = xx;
                    if (yy < ymn) ymn = yy;
                    if (yy > ymx) ymx = yy;
                end
            end
        end
        r.pix   = 20'(cnt);
        r.found = (cnt >= minp);
        r.xmin  = r.found ? 10'(xmn) : 10'd0;
        r.xmax  = r.found ? 10'(xmx) : 10'd0;
        r.ymin  = r.found ? 10'(ymn) : 10'd0;
        r.ymax  = r.found ? 10'(ymx) : 10'd0;
        return r;
    endfunction

    function automatic logic [23:0] expect_pixel(input bit h, input bit b, input int xx, input int yy);
        bit border;
        border = (((xx == int'(eb.xmin)) || (xx == int'(eb.xmax))) &&
                  (yy >= int'(eb.ymin)) && (yy <= int'(eb.ymax))) ||
                 (((yy == int'(eb.ymin)) || (yy == int'(eb.ymax))) &&
                  (xx >= int'(eb.xmin)) && (xx <= int'(eb.xmax)));
        if (!h) return 24'h000000;
        if (eb.found && border) return 24'hFF0000;
        return b ? 24'hFFFFFF : 24'h000000;
    endfunction

    task automatic clear_img();
        for (int yy = 0; yy < VD; yy++)
            for (int xx = 0; xx < HD; xx++)
                img[yy][xx] = 1'b0;
    endtask

    // One clock of stimulus: check last cycle's overlay and the box_valid
    // schedule, then drive this cycle and queue its expected overlay.
    task automatic applyStimulus(input bit v, input bit h, input bit b, input int xx, input int yy,
                                 input bit chk, input bit latch);
        pix_t p;
        pix_t e;
        @(posedge clk);
        #1;
        if (qpix.size() != 0) begin
            p = qpix.pop_front();
            checkOutput("post_img", a_img, p.img);
            checkOutput("post_sync", {a_pv, a_ph, a_pc}, {p.v, p.h, p.c});
        end
        checkOutput("box_valid_dut1", a_valid, valid_due);
        checkOutput("box_valid_dut4", b_valid, valid_due);
        valid_due = latch;
        vsync  = v;
        href   = h;
        clken  = h;
        bit_in = b;
        if (chk) begin
            e.img = expect_pixel(h, b, xx, yy);
            e.v = v;
            e.h = h;
            e.c = h;
            qpix.push_back(e);
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_box_dut1", {a_xmin, a_xmax, a_ymin, a_ymax}, 40'h0);
        checkOutput("rst_pix_dut1", {a_pix, a_found, a_valid}, 22'h0);
        checkOutput("rst_post_dut1", {a_img, a_pv, a_ph, a_pc}, 27'h0);
        checkOutput("rst_box_dut4", {b_xmin, b_xmax, b_ymin, b_ymax, b_found}, 41'h0);
    endtask

    task automatic run_frame(input bit chk, input bit report, input int rst_line);
        res_t r1;
        res_t r4;
        r1 = calc(1);
        r4 = calc(4);
        if (report) begin
            q1.push_back(r1);
            q4.push_back(r4);
        end
        repeat (2) applyStimulus(1, 0, 0, 0, 0, chk, 0);
        for (int yy = 0; yy < VD; yy++) begin
            if (yy == rst_line) begin
                @(posedge clk);
                #1;
                rst = 1'b1;
                #1;
                checkResetState();
                eb = '{default: '0};
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
            end
            for (int xx = 0; xx < HD; xx++)
                applyStimulus(1, 1, img[yy][xx], xx, yy, chk, 0);
            repeat (2) applyStimulus(1, 0, 0, 0, 0, chk, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, chk, report);
        if (report) eb = r1;
        repeat (3) applyStimulus(0, 0, 0, 0, 0, chk, 0);
    endtask

    // Box results are popped from the scoreboard whenever a DUT reports.
    always @(negedge clk) begin
        res_t r;
        if (!rst && a_valid) begin
            n_assert++;
            assert (q1.size() != 0) else begin
                n_fail++;
                $error("[TB] FAIL spurious_valid_dut1: observed pulse expected none");
            end
            if (q1.size() != 0) begin
                r = q1.pop_front();
                checkOutput("dut1_box", {a_xmin, a_xmax, a_ymin, a_ymax}, {r.xmin, r.xmax, r.ymin, r.ymax});
                checkOutput("dut1_pixels", a_pix, r.pix);
                checkOutput("dut1_found", a_found, r.found);
            end
        end
        if (!rst && b_valid) begin
            n_assert++;
            assert (q4.size() != 0) else begin
                n_fail++;
                $error("[TB] FAIL spurious_valid_dut4: observed pulse expected none");
            end
            if (q4.size() != 0) begin
                r = q4.pop_front();
                checkOutput("dut4_box", {b_xmin, b_xmax, b_ymin, b_ymax}, {r.xmin, r.xmax, r.ymin, r.ymax});
                checkOutput("dut4_pixels", b_pix, r.pix);
                checkOutput("dut4_found", b_found, r.found);
            end
        end
    end

    initial begin
        eb = '{default: '0};
        clear_img();
        repeat (2) @(posedge clk);
        #1;
        checkResetState();
        rst = 1'b0;
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 1, 0);

        $display("[TB] frame A: single pixel (5,3)");
        clear_img();
        img[3][5] = 1'b1;
        run_frame(1, 1, -1);

        $display("[TB] frame B: all black, overlay of frame A box");
        clear_img();
        run_frame(1, 1, -1);

        $display("[TB] frame C: block (2..3,1..2) plus (10,6)");
        clear_img();
        img[1][2] = 1'b1; img[1][3] = 1'b1;
        img[2][2] = 1'b1; img[2][3] = 1'b1;
        img[6][10] = 1'b1;
        run_frame(1, 1, -1);

        $display("[TB] frame D: three pixels, overlay of frame C box");
        clear_img();
        img[1][1] = 1'b1; img[4][7] = 1'b1; img[7][14] = 1'b1;
        run_frame(1, 1, -1);

        $display("[TB] frame E: reset at line 4");
        clear_img();
        img[2][6] = 1'b1; img[5][9] = 1'b1;
        run_frame(0, 0, 4);

        $display("[TB] frame F: corners plus (8,2) after reset");
        clear_img();
        img[0][0] = 1'b1; img[7][15] = 1'b1; img[2][8] = 1'b1;
        run_frame(1, 1, -1);

        repeat (4) applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("pending_results_dut1", q1.size(), 0);
        checkOutput("pending_results_dut4", q4.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
